mm_control_unit: RTL and testbench

- Multi-cycle sequencer on the driving side of the datapath ALU interface.
- Fetches 16-bit instructions and decodes them into alu_op, operand-select, accumulator-write and data-memory strobes.
- Consumes the ALU zero flag for conditional branches.
- Sits between instruction memory, data memory and the accumulator datapath of the matrix-multiply core.

---
 rtl/mm_cu_pkg.sv | 44 ++++
 rtl/mm_cu_decode.sv | 73 +++++++
 rtl/mm_control_unit.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_mm_control_unit.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_cu_pkg.sv
// -----------------------------------------------------------------------------
// mm_cu_pkg
// Shared definitions for the matrix-multiply core control unit:
//   - opcode values held in instruction bits [15:12]
//   - ALU operation codes driven on alu_op
//   - sequencer state encoding
// Optional feature macro used by the importing files: MM_CU_HW_LOOP_EN
// (enables the SETL/LOOP hardware loop opcodes).
// -----------------------------------------------------------------------------
package mm_cu_pkg;

    localparam int OPC_W = 4;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_MUL   = 4'h5;
    localparam logic [3:0] OP_DIV   = 4'h6;
    localparam logic [3:0] OP_JMP   = 4'h7;
    localparam logic [3:0] OP_JZ    = 4'h8;
    localparam logic [3:0] OP_JNZ   = 4'h9;
    localparam logic [3:0] OP_LDI   = 4'hA;
    localparam logic [3:0] OP_SETL  = 4'hB;
    localparam logic [3:0] OP_LOOP  = 4'hC;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_MUL  = 3'd2;
    localparam logic [2:0] ALU_DIV  = 3'd3;
    localparam logic [2:0] ALU_PASS = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LATCH  = 3'd2,
        EXEC   = 3'd3,
        ALU    = 3'd4,
        HALTED = 3'd5
    } state_t;

endpackage

// File: rtl/mm_cu_decode.sv
// -----------------------------------------------------------------------------
// mm_cu_decode
// Purely combinational opcode decoder for the control unit.
// Ports:
//   opcode_i     in   4  instruction opcode field
//   needs_mem_o  out  1  instruction reads data memory and then writes the AC
//   alu_op_o     out  3  ALU operation for accumulator-writing instructions
//   is_branch_o  out  1  instruction may redirect the program counter
//   is_illegal_o out  1  opcode is not defined in this build
// Macro MM_CU_HW_LOOP_EN: when defined, SETL/LOOP decode as legal and LOOP is
// a branch; otherwise both are illegal.
// -----------------------------------------------------------------------------
module mm_cu_decode
    import mm_cu_pkg::*;
(
    input  logic [OPC_W-1:0] opcode_i,
    output logic             needs_mem_o,
    output logic [2:0]       alu_op_o,
    output logic             is_branch_o,
    output logic             is_illegal_o
);

    // Opcode to control-field lookup
    always_comb begin
        needs_mem_o  = 1'b0;
        alu_op_o     = ALU_ADD;
        is_branch_o  = 1'b0;
        is_illegal_o = 1'b0;
        case (opcode_i)
            OP_LOAD: begin
                needs_mem_o = 1'b1;
                alu_op_o    = ALU_PASS;
            end
            OP_ADD: begin
                needs_mem_o = 1'b1;
                alu_op_o    = ALU_ADD;
            end
            OP_SUB: begin
                needs_mem_o = 1'b1;
                alu_op_o    = ALU_SUB;
            end
            OP_MUL: begin
                needs_mem_o = 1'b1;
                alu_op_o    = ALU_MUL;
            end
            OP_DIV: begin
                needs_mem_o = 1'b1;
                alu_op_o    = ALU_DIV;
            end
            OP_LDI: begin
                alu_op_o = ALU_PASS;
            end
            OP_JMP, OP_JZ, OP_JNZ: begin
                is_branch_o = 1'b1;
            end
            OP_NOP, OP_STORE, OP_HALT: begin
                is_branch_o = 1'b0;
            end
`ifdef MM_CU_HW_LOOP_EN
            OP_SETL: begin
                is_branch_o = 1'b0;
            end
            OP_LOOP: begin
                is_branch_o = 1'b1;
            end
`endif
            default: begin
                is_illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mm_control_unit.sv
// -----------------------------------------------------------------------------
// mm_control_unit
// Multi-cycle sequencer driving the accumulator datapath of the matrix-multiply
// core: FETCH -> LATCH -> EXEC (-> ALU) per instruction, HALTED on HALT or an
// undefined opcode. Every output is a flop whose next value is derived from
// the state being entered, so nothing reaches a port combinationally from
// imem_rdata or z.
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               one-cycle pulse, runs from PC 0 when IDLE/HALTED
//   imem_addr/re/rdata  instruction memory (data valid the cycle after re)
//   dmem_addr/re/we     data memory strobes, address = operand field
//   alu_op, in2_sel     ALU operation and in2 source (0 dmem, 1 imm)
//   imm                 operand field for immediate instructions
//   ac_we               accumulator write enable
//   z                   ALU zero flag (true when non-zero), sampled with ac_we
//   busy, done          running / halted status
//   illegal             sticky, set by an undefined opcode, cleared by start
// Macro MM_CU_HW_LOOP_EN: adds the LOOP_W-bit loop counter with SETL/LOOP.
// -----------------------------------------------------------------------------
module mm_control_unit
    import mm_cu_pkg::*;
#(
    parameter int PC_W    = 12,
    parameter int INSTR_W = 16,
    parameter int LOOP_W  = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [PC_W-1:0]    imem_addr,
    output logic               imem_re,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [PC_W-1:0]    dmem_addr,
    output logic               dmem_re,
    output logic               dmem_we,
    output logic [2:0]         alu_op,
    output logic               in2_sel,
    output logic [PC_W-1:0]    imm,
    output logic               ac_we,
    input  logic [1:0]         z,
    output logic               busy,
    output logic               done,
    output logic               illegal
);

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               zf_q, zf_d;
    logic               illegal_q, illegal_d;

    logic [PC_W-1:0]    imem_addr_q, imem_addr_d;
    logic               imem_re_q, imem_re_d;
    logic [PC_W-1:0]    dmem_addr_q, dmem_addr_d;
    logic               dmem_re_q, dmem_re_d;
    logic               dmem_we_q, dmem_we_d;
    logic [2:0]         alu_op_q, alu_op_d;
    logic               in2_sel_q, in2_sel_d;
    logic [PC_W-1:0]    imm_q, imm_d;
    logic               ac_we_q, ac_we_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

`ifdef MM_CU_HW_LOOP_EN
    localparam logic [LOOP_W-1:0] LC_ONE = LOOP_W'(1);
    logic [LOOP_W-1:0]  lc_q, lc_d;
`endif

    logic [OPC_W-1:0]   opcode_s;
    logic [PC_W-1:0]    operand_s;
    logic               dec_needs_mem_s;
    logic [2:0]         dec_alu_op_s;
    logic               dec_is_branch_s;
    logic               dec_is_illegal_s;
    logic               take_branch_s;

    // Instruction register: captures the fetched word at the end of LATCH
    always_comb begin
        if (state_q == LATCH) begin
            ir_d = imem_rdata;
        end else begin
            ir_d = ir_q;
        end
    end

    // Decode looks at ir_d so the EXEC-cycle strobes can be registered on
    // entry to EXEC; during EXEC ir_d equals ir_q.
    assign opcode_s  = ir_d[INSTR_W-1 -: OPC_W];
    assign operand_s = ir_d[PC_W-1:0];

    mm_cu_decode u_decode (
        .opcode_i     (opcode_s),
        .needs_mem_o  (dec_needs_mem_s),
        .alu_op_o     (dec_alu_op_s),
        .is_branch_o  (dec_is_branch_s),
        .is_illegal_o (dec_is_illegal_s)
    );

    // Branch condition for the instruction in EXEC
    always_comb begin
        take_branch_s = 1'b0;
        case (opcode_s)
            OP_JMP:  take_branch_s = 1'b1;
            OP_JZ:   take_branch_s = zf_q;
            OP_JNZ:  take_branch_s = ~zf_q;
`ifdef MM_CU_HW_LOOP_EN
            OP_LOOP: take_branch_s = (lc_q > LC_ONE);
`endif
            default: take_branch_s = 1'b0;
        endcase
    end

    // Sequencer next state, architectural registers and next output values
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        illegal_d = illegal_q;
`ifdef MM_CU_HW_LOOP_EN
        lc_d      = lc_q;
`endif
        // The zero flag follows z only while the accumulator is written
        if (ac_we_q) begin
            zf_d = (z != 2'b00);
        end else begin
            zf_d = zf_q;
        end

        case (state_q)
            IDLE, HALTED: begin
                if (start) begin
                    pc_d      = {PC_W{1'b0}};
                    illegal_d = 1'b0;
                    state_d   = FETCH;
                end else begin
                    state_d   = state_q;
                end
            end
            FETCH: begin
                state_d = LATCH;
            end
            LATCH: begin
                pc_d    = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
                state_d = EXEC;
            end
            EXEC: begin
                if (dec_is_illegal_s) begin
                    illegal_d = 1'b1;
                    state_d   = HALTED;
                end else if (dec_needs_mem_s) begin
                    state_d   = ALU;
                end else if (opcode_s == OP_HALT) begin
                    state_d   = HALTED;
                end else begin
                    state_d   = FETCH;
                end
                if (dec_is_branch_s && take_branch_s) begin
                    pc_d = operand_s;
                end else begin
                    pc_d = pc_q;
                end
`ifdef MM_CU_HW_LOOP_EN
                if (opcode_s == OP_SETL) begin
                    lc_d = LOOP_W'(operand_s);
                end else if (opcode_s == OP_LOOP) begin
                    // Last pass (lc 1) and an unarmed loop (lc 0) both end at 0
                    if (lc_q > LC_ONE) begin
                        lc_d = lc_q - LC_ONE;
                    end else begin
                        lc_d = {LOOP_W{1'b0}};
                    end
                end else begin
                    lc_d = lc_q;
                end
`endif
            end
            ALU: begin
                state_d = FETCH;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Output values for the cycle spent in state_d
        if (state_d == FETCH) begin
            imem_re_d   = 1'b1;
            imem_addr_d = pc_d;
        end else begin
            imem_re_d   = 1'b0;
            imem_addr_d = imem_addr_q;
        end

        if (state_d == EXEC) begin
            dmem_addr_d = operand_s;
            imm_d       = operand_s;
            dmem_re_d   = dec_needs_mem_s;
            dmem_we_d   = (opcode_s == OP_STORE);
            if (opcode_s == OP_LDI) begin
                alu_op_d  = dec_alu_op_s;
                in2_sel_d = 1'b1;
                ac_we_d   = 1'b1;
            end else begin
                alu_op_d  = alu_op_q;
                in2_sel_d = in2_sel_q;
                ac_we_d   = 1'b0;
            end
        end else if (state_d == ALU) begin
            dmem_addr_d = dmem_addr_q;
            imm_d       = imm_q;
            dmem_re_d   = 1'b0;
            dmem_we_d   = 1'b0;
            alu_op_d    = dec_alu_op_s;
            in2_sel_d   = 1'b0;
            ac_we_d     = 1'b1;
        end else begin
            dmem_addr_d = dmem_addr_q;
            imm_d       = imm_q;
            dmem_re_d   = 1'b0;
            dmem_we_d   = 1'b0;
            alu_op_d    = alu_op_q;
            in2_sel_d   = in2_sel_q;
            ac_we_d     = 1'b0;
        end

        busy_d = (state_d != IDLE) && (state_d != HALTED);
        done_d = (state_d == HALTED);
    end

    // State, architectural registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= {PC_W{1'b0}};
            ir_q        <= {INSTR_W{1'b0}};
            zf_q        <= 1'b0;
            illegal_q   <= 1'b0;
            imem_addr_q <= {PC_W{1'b0}};
            imem_re_q   <= 1'b0;
            dmem_addr_q <= {PC_W{1'b0}};
            dmem_re_q   <= 1'b0;
            dmem_we_q   <= 1'b0;
            alu_op_q    <= 3'd0;
            in2_sel_q   <= 1'b0;
            imm_q       <= {PC_W{1'b0}};
            ac_we_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef MM_CU_HW_LOOP_EN
            lc_q        <= {LOOP_W{1'b0}};
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            zf_q        <= zf_d;
            illegal_q   <= illegal_d;
            imem_addr_q <= imem_addr_d;
            imem_re_q   <= imem_re_d;
            dmem_addr_q <= dmem_addr_d;
            dmem_re_q   <= dmem_re_d;
            dmem_we_q   <= dmem_we_d;
            alu_op_q    <= alu_op_d;
            in2_sel_q   <= in2_sel_d;
            imm_q       <= imm_d;
            ac_we_q     <= ac_we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef MM_CU_HW_LOOP_EN
            lc_q        <= lc_d;
`endif
        end
    end

    assign imem_addr = imem_addr_q;
    assign imem_re   = imem_re_q;
    assign dmem_addr = dmem_addr_q;
    assign dmem_re   = dmem_re_q;
    assign dmem_we   = dmem_we_q;
    assign alu_op    = alu_op_q;
    assign in2_sel   = in2_sel_q;
    assign imm       = imm_q;
    assign ac_we     = ac_we_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_mm_control_unit.sv
// -----------------------------------------------------------------------------
// tb_mm_control_unit
// Self-checking bench for mm_control_unit. An instruction-level model of the
// ISA (pc, zf, loop counter, cycle count per opcode) predicts the fetch
// sequence, the strobes seen between fetches and the halt status; directed
// programs cover the listed scenarios and random programs cover the rest.
// Honours MM_CU_HW_LOOP_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_mm_control_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [11:0] imem_addr;
    logic        imem_re;
    logic [15:0] imem_rdata;
    logic [11:0] dmem_addr;
    logic        dmem_re;
    logic        dmem_we;
    logic [2:0]  alu_op;
    logic        in2_sel;
    logic [11:0] imm;
    logic        ac_we;
    logic [1:0]  z;
    logic        busy;
    logic        done;
    logic        illegal;

    mm_control_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .imem_addr  (imem_addr),
        .imem_re    (imem_re),
        .imem_rdata (imem_rdata),
        .dmem_addr  (dmem_addr),
        .dmem_re    (dmem_re),
        .dmem_we    (dmem_we),
        .alu_op     (alu_op),
        .in2_sel    (in2_sel),
        .imm        (imm),
        .ac_we      (ac_we),
        .z          (z),
        .busy       (busy),
        .done       (done),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:4095];

    int          n_tests;
    int          n_fail;
    int          z_force;
    int          add_seen;
    int          last_tot;
    logic [11:0] last_fetch;

    // Reference model state
    logic [11:0] m_pc;
    logic        m_zf;
    logic [11:0] m_lc;
    logic        m_ill;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] outs_vec();
        return 64'({imem_addr, imem_re, dmem_addr, dmem_re, dmem_we, alu_op,
                    in2_sel, imm, ac_we, busy, done, illegal});
    endfunction

    task automatic fill_halt();
        for (int a = 0; a < 4096; a++) mem[a] = 16'hF000;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        z     = 2'b00;
        #3;
        chk("reset_outputs", outs_vec(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_zf  = 1'b0;
        m_lc  = 12'd0;
        m_ill = 1'b0;
        @(negedge clk);
    endtask

    // Pulse start and follow the program instruction by instruction.
    task automatic run_prog(input int max_instr);
        logic [15:0] ins;
        logic [3:0]  op;
        logic [11:0] opd, nxt, we_a, re_a, imm_s;
        logic [2:0]  alu_s, e_alu;
        logic        sel_s, e_sel, e_we, e_re, e_acw, e_halt;
        int          lat, n, we_c, re_c, acw_c, tot, exp_tot, zv;
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        m_pc    = 12'd0;
        m_ill   = 1'b0;
        tot     = 0;
        exp_tot = 0;
        for (int k = 0; k < max_instr; k++) begin
            chk("fetch_re", 64'(imem_re), 64'd1);
            chk("fetch_pc", 64'(imem_addr), 64'(m_pc));
            if (k == 0) chk("start_status", 64'({busy, done, illegal}), 64'd4);
            last_fetch = imem_addr;
            imem_rdata = mem[imem_addr];
            zv = (z_force >= 0) ? z_force : int'($urandom_range(0, 3));
            z  = 2'(zv);

            ins    = mem[m_pc];
            op     = ins[15:12];
            opd    = ins[11:0];
            nxt    = m_pc + 12'd1;
            lat    = 3;
            e_we   = 1'b0;
            e_re   = 1'b0;
            e_acw  = 1'b0;
            e_halt = 1'b0;
            e_alu  = 3'd0;
            e_sel  = 1'b0;
            case (op)
                4'h1, 4'h3, 4'h4, 4'h5, 4'h6: begin
                    lat   = 4;
                    e_re  = 1'b1;
                    e_acw = 1'b1;
                    // LOAD passes in2; ADD..DIV map to ALU codes 0..3
                    e_alu = (op == 4'h1) ? 3'd4 : 3'(op - 4'h3);
                    m_zf  = (zv != 0);
                end
                4'h2: e_we = 1'b1;
                4'h7: nxt = opd;
                4'h8: if (m_zf) nxt = opd;
                4'h9: if (!m_zf) nxt = opd;
                4'hA: begin
                    e_acw = 1'b1;
                    e_alu = 3'd4;
                    e_sel = 1'b1;
                    m_zf  = (zv != 0);
                end
                4'hF: e_halt = 1'b1;
                4'h0: e_halt = 1'b0;
`ifdef MM_CU_HW_LOOP_EN
                4'hB: m_lc = opd;
                4'hC: begin
                    if (m_lc > 12'd1) begin
                        m_lc = m_lc - 12'd1;
                        nxt  = opd;
                    end else begin
                        m_lc = 12'd0;
                    end
                end
`endif
                default: begin
                    e_halt = 1'b1;
                    m_ill  = 1'b1;
                end
            endcase

            n = 0; we_c = 0; re_c = 0; acw_c = 0;
            we_a = 12'd0; re_a = 12'd0; imm_s = 12'd0; alu_s = 3'd0; sel_s = 1'b0;
            do begin
                @(negedge clk);
                n++;
                if (dmem_we) begin we_c++; we_a = dmem_addr; end
                if (dmem_re) begin re_c++; re_a = dmem_addr; end
                if (ac_we) begin
                    acw_c++;
                    alu_s = alu_op;
                    sel_s = in2_sel;
                    imm_s = imm;
                    if (alu_op == 3'd0) add_seen++;
                end
            end while (!imem_re && !done && n < 8);
            tot     += n;
            exp_tot += lat;

            chk("latency", 64'(n), 64'(lat));
            chk("dmem_we_cycles", 64'(we_c), 64'(e_we));
            chk("dmem_re_cycles", 64'(re_c), 64'(e_re));
            chk("ac_we_cycles", 64'(acw_c), 64'(e_acw));
            if (e_we) chk("store_addr", 64'(we_a), 64'(opd));
            if (e_re) chk("load_addr", 64'(re_a), 64'(opd));
            if (e_acw) begin
                chk("alu_op", 64'(alu_s), 64'(e_alu));
                chk("in2_sel", 64'(sel_s), 64'(e_sel));
                if (op == 4'hA) chk("ldi_imm", 64'(imm_s), 64'(opd));
            end
            if (e_halt) begin
                chk("halt_status", 64'({busy, done, illegal}), 64'({2'b01, m_ill}));
                chk("total_cycles", 64'(tot), 64'(exp_tot));
                last_tot = tot;
                break;
            end
            m_pc = nxt;
        end
    endtask

    task automatic gen_random();
        logic [3:0]  op;
        logic [11:0] opd;
        fill_halt();
        for (int a = 0; a < 20; a++) begin
            op = 4'($urandom_range(0, 15));
            // Thin out program-ending opcodes so runs get some length
            if ((op >= 4'hD) && ($urandom_range(0, 3) != 0)) op = 4'h3;
            case (op)
                4'h7, 4'h8, 4'h9, 4'hC: opd = 12'($urandom_range(0, 21));
                4'hB:                   opd = 12'($urandom_range(0, 4));
                default:                opd = 12'($urandom);
            endcase
            mem[a] = {op, opd};
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        z_force    = -1;
        add_seen   = 0;
        last_tot   = 0;
        last_fetch = 12'd0;
        rst_n      = 1'b1;
        start      = 1'b0;
        z          = 2'b00;
        imem_rdata = 16'd0;
        m_zf = 1'b0; m_lc = 12'd0; m_ill = 1'b0; m_pc = 12'd0;
        #2;
        do_reset();

        // LDI 5; STORE 0x010; HALT
        fill_halt();
        mem[0] = 16'hA005; mem[1] = 16'h2010; mem[2] = 16'hF000;
        run_prog(10);
        chk("t1_done_cycle", 64'(last_tot), 64'd9);

        // LOAD 0x020; SUB 0x020; JZ 0x007, with z true then false
        fill_halt();
        mem[0] = 16'h1020; mem[1] = 16'h4020; mem[2] = 16'h8007;
        z_force = 1;
        run_prog(10);
        chk("jz_taken_fetch", 64'(last_fetch), 64'h007);
        z_force = 0;
        run_prog(10);
        chk("jz_fall_fetch", 64'(last_fetch), 64'h003);
        z_force = -1;

        // PC wrap: JMP 0xFFF, NOP at 4095, back to 0
        do_reset();
        fill_halt();
        mem[0] = 16'h7FFF; mem[4095] = 16'h0000;
        run_prog(5);
        chk("wrap_fetch", 64'(last_fetch), 64'h000);
        do_reset();

        // Undefined opcode 0xE at PC 2, then a clean re-run
        fill_halt();
        mem[0] = 16'h0000; mem[1] = 16'h0000; mem[2] = 16'hE000;
        run_prog(10);
        chk("illegal_set", 64'({illegal, done}), 64'd3);
        mem[2] = 16'hF000;
        run_prog(10);
        chk("illegal_cleared", 64'(illegal), 64'd0);

        // Reset during the EXEC cycle of STORE
        fill_halt();
        mem[0] = 16'h2010;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        imem_rdata = mem[imem_addr];
        for (int i = 0; i < 6 && !dmem_we; i++) @(negedge clk);
        chk("store_we_seen", 64'({dmem_we, dmem_addr}), 64'h1010);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_drop_we", 64'(dmem_we), 64'd0);
        chk("async_reset_outs", outs_vec(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_zf = 1'b0; m_lc = 12'd0; m_ill = 1'b0;
        @(negedge clk);

        // Hardware loop: SETL 3; ADD 0x030; LOOP 0x001; HALT
        fill_halt();
        mem[0] = 16'hB003; mem[1] = 16'h3030; mem[2] = 16'hC001; mem[3] = 16'hF000;
        add_seen = 0;
        run_prog(30);
`ifdef MM_CU_HW_LOOP_EN
        chk("loop_add_count", 64'(add_seen), 64'd3);
        // Counter must be 0 after the loop: LOOP now falls through
        fill_halt();
        mem[0] = 16'hC005; mem[1] = 16'hF000;
        run_prog(5);
        chk("loop_zero_fall", 64'(last_fetch), 64'h001);
`else
        chk("setl_illegal", 64'({illegal, 7'(add_seen)}), 64'h80);
`endif

        // Random programs against the model
        for (int r = 0; r < 40; r++) begin
            do_reset();
            gen_random();
            run_prog(40);
        end
        do_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
